// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line serial host.
// Holds the FSM state type, frame/response widths and the bit positions
// inside the 2-bit response setting.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX       = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RX       = 3'd3,
    ST_NCC_WAIT = 3'd4,
    ST_FIN      = 3'd5
  } state_t;

  localparam int CMD_FRAME_W = 48;
  localparam int RSP_SHORT_W = 48;
  localparam int RSP_LONG_W  = 136;
  localparam int CRC_W       = 7;

  // setting_i bit positions
  localparam int SET_RSP_BIT  = 0;
  localparam int SET_LONG_BIT = 1;

  // Bit counter covers the 136-bit long response and the NCC gap.
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sd_crc_7.sv
// Serial CRC7 generator/checker, polynomial x^7 + x^3 + 1, MSB first.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of the remainder (wins over en)
//   en       : shift bit_in into the remainder this cycle
//   bit_in   : serial data bit
//   crc      : current remainder
module sd_crc_7
  import sd_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb_s;

  assign fb_s = bit_in ^ crc[CRC_W-1];

  // Remainder register: LFSR form with taps at x^3 and x^0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 7'd0;
    end else if (clr) begin
      crc <= 7'd0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb_s}} & 7'h09);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/sd_cmd_serial_host.sv
// Bit-level SD CMD line engine. Serialises a 40-bit command with CRC7 and
// end bit, then optionally receives a 48- or 136-bit response, checking
// CRC7 and index.
// Ports:
//   sd_clk, rst          : SD clock, asynchronous active-high reset
//   start_i              : one-cycle request, honoured only in IDLE
//   setting_i[1:0]       : bit0 response expected, bit1 long response
//   cmd_i[39:0]          : {start, dir, index, arg}, captured with start_i
//   go_idle_i            : synchronous abort back to IDLE
//   cmd_dat_i            : CMD line from the pad
//   cmd_out_o, cmd_oe_o  : CMD line drive value and output enable
//   response_o[119:0]    : received content field, MSB aligned
//   crc_ok_o, index_ok_o : response checks, valid from the FIN cycle
//   finish_o             : one-cycle end-of-transfer pulse
module sd_cmd_serial_host
  import sd_cmd_pkg::*;
#(
  parameter int NCC = 8
) (
  input  logic          sd_clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    setting_i,
  input  logic [39:0]   cmd_i,
  input  logic          go_idle_i,
  input  logic          cmd_dat_i,
  output logic          cmd_out_o,
  output logic          cmd_oe_o,
  output logic [119:0]  response_o,
  output logic          crc_ok_o,
  output logic          index_ok_o,
  output logic          finish_o
);

  // The first two response bits (start, direction) are never needed, so the
  // shift register keeps only the low RSP_LONG_W-2 bits.
  localparam int RX_KEEP_W = RSP_LONG_W - 2;

  state_t                 state_r;
  state_t                 state_nxt_s;
  cnt_t                   cnt_r;
  logic [39:0]            cmd_r;
  logic                   rsp_r;
  logic                   long_r;
  logic [RX_KEEP_W-2:0]   rx_sr_r;
  logic [RX_KEEP_W-1:0]   rx_full_s;
  logic                   cmd_out_r;
  logic                   cmd_oe_r;
  logic                   finish_r;
  logic [119:0]           response_r;
  logic                   crc_ok_r;
  logic                   index_ok_r;

  logic [CRC_W-1:0]       crc_s;
  logic                   crc_en_s;
  logic                   crc_clr_s;
  logic                   crc_bit_s;
  logic [CMD_FRAME_W-1:0] tx_word_s;
  logic [5:0]             tx_idx_s;
  logic                   tx_bit_s;
  cnt_t                   last_cnt_s;
  logic                   crc_cover_s;
  logic                   rx_start_s;

  sd_crc_7 u_crc (
    .clk    (sd_clk),
    .rst    (rst),
    .clr    (crc_clr_s),
    .en     (crc_en_s),
    .bit_in (crc_bit_s),
    .crc    (crc_s)
  );

  // CRC bits are only selected once cnt reaches 40, by which time the
  // remainder is final, so the live CRC can sit in the frame word.
  assign tx_word_s  = {cmd_r, crc_s, 1'b1};
  assign tx_idx_s   = 6'd47 - cnt_r[5:0];
  assign tx_bit_s   = tx_word_s[tx_idx_s];
  assign rx_full_s  = {rx_sr_r, cmd_dat_i};
  assign last_cnt_s = long_r ? cnt_t'(RSP_LONG_W - 1) : cnt_t'(RSP_SHORT_W - 1);
  // Short CRC covers bits 47..8 (start bit is a no-op on a cleared CRC);
  // long CRC covers only the 120-bit content, bits 127..8.
  assign crc_cover_s = long_r ? ((cnt_r >= 8'd8) && (cnt_r <= 8'd127))
                              : (cnt_r <= 8'd39);
  // Our own drive must be released before a low line counts as a start bit.
  assign rx_start_s = !cmd_oe_r && !cmd_dat_i;

  // FSM state register.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and CRC control.
  always_comb begin
    state_nxt_s = state_r;
    crc_en_s    = 1'b0;
    crc_clr_s   = 1'b0;
    crc_bit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_TX;
          crc_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TX: begin
        crc_bit_s = tx_bit_s;
        crc_en_s  = (cnt_r <= 8'd39);
        if (cnt_r == cnt_t'(CMD_FRAME_W - 1)) begin
          state_nxt_s = rsp_r ? ST_WAIT : ST_NCC_WAIT;
        end else begin
          state_nxt_s = ST_TX;
        end
      end
      ST_WAIT: begin
        if (rx_start_s) begin
          state_nxt_s = ST_RX;
          crc_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RX: begin
        crc_bit_s = cmd_dat_i;
        crc_en_s  = crc_cover_s;
        if (cnt_r == last_cnt_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_RX;
        end
      end
      ST_NCC_WAIT: begin
        if (cnt_r == cnt_t'(NCC - 1)) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_NCC_WAIT;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (go_idle_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Datapath: command capture, bit counter, line drive, response capture.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= cnt_t'(0);
      cmd_r      <= 40'd0;
      rsp_r      <= 1'b0;
      long_r     <= 1'b0;
      rx_sr_r    <= '0;
      cmd_out_r  <= 1'b1;
      cmd_oe_r   <= 1'b0;
      finish_r   <= 1'b0;
      response_r <= 120'd0;
      crc_ok_r   <= 1'b0;
      index_ok_r <= 1'b0;
    end else begin
      // finish follows the FIN state by one edge.
      finish_r <= (state_r == ST_FIN) && !go_idle_i;
      if (go_idle_i) begin
        cmd_out_r <= 1'b1;
        cmd_oe_r  <= 1'b0;
        cnt_r     <= cnt_t'(0);
      end else begin
        case (state_r)
          ST_IDLE: begin
            cmd_out_r <= 1'b1;
            cmd_oe_r  <= 1'b0;
            if (start_i) begin
              cmd_r      <= cmd_i;
              rsp_r      <= setting_i[SET_RSP_BIT];
              long_r     <= setting_i[SET_RSP_BIT] & setting_i[SET_LONG_BIT];
              cnt_r      <= cnt_t'(0);
              response_r <= 120'd0;
              crc_ok_r   <= 1'b0;
              index_ok_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          ST_TX: begin
            cmd_out_r <= tx_bit_s;
            cmd_oe_r  <= 1'b1;
            if (cnt_r == cnt_t'(CMD_FRAME_W - 1)) begin
              cnt_r <= cnt_t'(0);
            end else begin
              cnt_r <= cnt_r + cnt_t'(1);
            end
          end
          ST_WAIT: begin
            cmd_out_r <= 1'b1;
            cmd_oe_r  <= 1'b0;
            if (rx_start_s) begin
              cnt_r   <= cnt_t'(1);
              rx_sr_r <= '0;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          ST_RX: begin
            rx_sr_r <= rx_full_s[RX_KEEP_W-2:0];
            cnt_r   <= cnt_r + cnt_t'(1);
            if (cnt_r == last_cnt_s) begin
              crc_ok_r <= (rx_full_s[7:1] == crc_s) && rx_full_s[0];
              if (long_r) begin
                response_r <= rx_full_s[127:8];
                index_ok_r <= (rx_full_s[133:128] == 6'h3F);
              end else begin
                response_r <= {rx_full_s[39:8], 88'd0};
                index_ok_r <= (rx_full_s[45:40] == cmd_r[37:32]);
              end
            end else begin
              response_r <= response_r;
            end
          end
          ST_NCC_WAIT: begin
            cmd_out_r <= 1'b1;
            cmd_oe_r  <= 1'b0;
            cnt_r     <= cnt_r + cnt_t'(1);
          end
          ST_FIN: begin
            cnt_r <= cnt_t'(0);
          end
          default: begin
            cmd_out_r <= 1'b1;
            cmd_oe_r  <= 1'b0;
            cnt_r     <= cnt_t'(0);
          end
        endcase
      end
    end
  end

  assign cmd_out_o  = cmd_out_r;
  assign cmd_oe_o   = cmd_oe_r;
  assign finish_o   = finish_r;
  assign response_o = response_r;
  assign crc_ok_o   = crc_ok_r;
  assign index_ok_o = index_ok_r;

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// Self-checking bench for sd_cmd_serial_host: table of transfers with a
// card model and a scoreboard of expected results, plus hand sequences for
// abort, reset during TX and start during RX.
module tb_sd_cmd_serial_host;
  import sd_cmd_pkg::*;

  localparam int NCC = 8;

  logic         sd_clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   setting_i;
  logic [39:0]  cmd_i;
  logic         go_idle_i;
  logic         cmd_dat_i;
  logic         cmd_out_o;
  logic         cmd_oe_o;
  logic [119:0] response_o;
  logic         crc_ok_o;
  logic         index_ok_o;
  logic         finish_o;

  int errors = 0;
  int checks = 0;

  always #5 sd_clk = ~sd_clk;

  sd_cmd_serial_host #(.NCC(NCC)) dut (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .start_i    (start_i),
    .setting_i  (setting_i),
    .cmd_i      (cmd_i),
    .go_idle_i  (go_idle_i),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_out_o  (cmd_out_o),
    .cmd_oe_o   (cmd_oe_o),
    .response_o (response_o),
    .crc_ok_o   (crc_ok_o),
    .index_ok_o (index_ok_o),
    .finish_o   (finish_o)
  );

  // kind: 0 none, 1 short, 2 long
  typedef struct {
    logic [39:0]  cmd;
    logic [1:0]   setting;
    int           kind;
    logic [5:0]   rsp_idx;
    logic [119:0] content;
    logic         flip_crc;
    logic         poke;
    logic [47:0]  exp_stream;
    logic [119:0] exp_resp;
    logic         exp_crc;
    logic         exp_idx;
  } vec_t;

  typedef struct {
    logic [119:0] resp;
    logic         crc;
    logic         idx;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  // CRC7 by polynomial long division of M(x)*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic [127:0] data, input int n);
    logic [134:0] r;
    r = {7'd0, data} << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame(input logic [39:0] c);
    return {c, crc7_div({88'd0, c}, 40), 1'b1};
  endfunction

  task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one transfer; called at #1 after a rising edge with the DUT idle.
  task automatic run_vec(input int id, input vec_t v);
    logic [47:0]  stream;
    logic         oe_ok;
    logic         fin_ok;
    logic [47:0]  r48;
    logic [135:0] reply;
    int           rlen;
    exp_t         e;
    start_i   = 1'b1;
    cmd_i     = v.cmd;
    setting_i = v.setting;
    cmd_dat_i = 1'b0;            // low line during TX must be ignored
    sb.push_back('{resp: v.exp_resp, crc: v.exp_crc, idx: v.exp_idx});
    @(posedge sd_clk); #1;
    start_i = 1'b0;
    stream  = 48'd0;
    oe_ok   = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(posedge sd_clk); #1;
      stream = {stream[46:0], cmd_out_o};
      if (cmd_oe_o !== 1'b1) oe_ok = 1'b0;
    end
    cmd_dat_i = 1'b1;
    check($sformatf("v%0d_stream", id), {72'd0, stream}, {72'd0, v.exp_stream});
    check($sformatf("v%0d_tx_oe", id), {119'd0, oe_ok}, 120'd1);
    @(posedge sd_clk); #1;
    check($sformatf("v%0d_oe_drop", id), {119'd0, cmd_oe_o}, 120'd0);
    if (v.kind == 0) begin
      fin_ok = 1'b1;
      for (int k = 1; k <= NCC; k++) begin
        @(posedge sd_clk); #1;
        if (finish_o !== (k == NCC)) fin_ok = 1'b0;
      end
      check($sformatf("v%0d_ncc_finish", id), {119'd0, fin_ok}, 120'd1);
    end else begin
      if (v.kind == 1) begin
        r48      = {2'b00, v.rsp_idx, v.content[31:0], 8'h00};
        r48[7:1] = crc7_div({88'd0, r48[47:8]}, 40);
        r48[0]   = 1'b1;
        if (v.flip_crc) r48[1] = ~r48[1];
        reply = {88'd0, r48};
        rlen  = 48;
      end else begin
        reply      = {2'b00, 6'h3F, v.content, 8'h00};
        reply[7:1] = crc7_div({8'd0, v.content}, 120);
        reply[0]   = 1'b1;
        if (v.flip_crc) reply[1] = ~reply[1];
        rlen = 136;
      end
      for (int k = 0; k < 5; k++) begin
        @(posedge sd_clk); #1;
      end
      for (int j = rlen - 1; j >= 0; j--) begin
        cmd_dat_i = reply[j];
        if (v.poke && j == 20) begin
          start_i   = 1'b1;
          cmd_i     = 40'h4000000000;
          setting_i = 2'b00;
        end else begin
          start_i = 1'b0;
        end
        @(posedge sd_clk); #1;
        if (v.poke && j == 20)
          check($sformatf("v%0d_poke_oe", id), {119'd0, cmd_oe_o}, 120'd0);
      end
      start_i   = 1'b0;
      fin_ok    = (finish_o === 1'b0);
      cmd_dat_i = 1'b1;
      @(posedge sd_clk); #1;
      if (finish_o !== 1'b1) fin_ok = 1'b0;
      check($sformatf("v%0d_rsp_finish", id), {119'd0, fin_ok}, 120'd1);
    end
    if (sb.size() == 0) begin
      check($sformatf("v%0d_sb_empty", id), 120'd0, 120'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d_response", id), response_o, e.resp);
      check($sformatf("v%0d_crc_ok", id), {119'd0, crc_ok_o}, {119'd0, e.crc});
      check($sformatf("v%0d_index_ok", id), {119'd0, index_ok_o}, {119'd0, e.idx});
    end
    @(posedge sd_clk); #1;
    check($sformatf("v%0d_finish_pulse", id), {119'd0, finish_o}, 120'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic quiet;
    vecs[0] = '{cmd: 40'h4000000000, setting: 2'b00, kind: 0, rsp_idx: 6'd0,
                content: 120'd0, flip_crc: 1'b0, poke: 1'b0,
                exp_stream: 48'h400000000095, exp_resp: 120'd0, exp_crc: 1'b0, exp_idx: 1'b0};
    vecs[1] = '{cmd: 40'h48000001AA, setting: 2'b01, kind: 1, rsp_idx: 6'd8,
                content: 120'h1AA, flip_crc: 1'b0, poke: 1'b0,
                exp_stream: 48'h48000001AA87, exp_resp: {32'h000001AA, 88'd0},
                exp_crc: 1'b1, exp_idx: 1'b1};
    vecs[2] = '{cmd: 40'h4712340000, setting: 2'b10, kind: 0, rsp_idx: 6'd0,
                content: 120'd0, flip_crc: 1'b0, poke: 1'b0,
                exp_stream: frame(40'h4712340000), exp_resp: 120'd0, exp_crc: 1'b0, exp_idx: 1'b0};
    vecs[3] = vecs[1];
    vecs[3].flip_crc = 1'b1;
    vecs[3].exp_crc  = 1'b0;
    vecs[4] = vecs[1];
    vecs[4].rsp_idx  = 6'd9;
    vecs[4].exp_idx  = 1'b0;
    vecs[5] = '{cmd: 40'h4200000000, setting: 2'b11, kind: 2, rsp_idx: 6'h3F,
                content: 120'h0102030405060708090a0b0c0d0e0f, flip_crc: 1'b0, poke: 1'b0,
                exp_stream: frame(40'h4200000000),
                exp_resp: 120'h0102030405060708090a0b0c0d0e0f, exp_crc: 1'b1, exp_idx: 1'b1};
    vecs[6] = vecs[1];
    vecs[6].poke = 1'b1;

    rst       = 1'b1;
    start_i   = 1'b0;
    setting_i = 2'b00;
    cmd_i     = 40'd0;
    go_idle_i = 1'b0;
    cmd_dat_i = 1'b1;
    @(negedge sd_clk);
    @(negedge sd_clk);
    check("reset_lines", {118'd0, cmd_out_o, cmd_oe_o}, 120'd2);
    check("reset_flags", {117'd0, finish_o, crc_ok_o, index_ok_o}, 120'd0);
    check("reset_response", response_o, 120'd0);
    rst = 1'b0;
    @(posedge sd_clk); #1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // No card reply, then abort; then abort plus start together in IDLE.
    start_i   = 1'b1;
    cmd_i     = 40'h48000001AA;
    setting_i = 2'b01;
    @(posedge sd_clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 49; i++) begin
      @(posedge sd_clk); #1;
    end
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge sd_clk); #1;
      if (finish_o !== 1'b0 || cmd_oe_o !== 1'b0) quiet = 1'b0;
    end
    check("no_reply_quiet", {119'd0, quiet}, 120'd1);
    go_idle_i = 1'b1;
    @(posedge sd_clk); #1;
    go_idle_i = 1'b0;
    check("go_idle_lines", {118'd0, cmd_oe_o, finish_o}, 120'd0);
    go_idle_i = 1'b1;
    start_i   = 1'b1;
    cmd_i     = 40'h4000000000;
    setting_i = 2'b00;
    @(posedge sd_clk); #1;
    go_idle_i = 1'b0;
    start_i   = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge sd_clk); #1;
      if (finish_o !== 1'b0 || cmd_oe_o !== 1'b0) quiet = 1'b0;
    end
    check("go_idle_priority", {119'd0, quiet}, 120'd1);
    run_vec(10, vecs[0]);

    // Reset in the middle of TX, at frame bit 20 (a 0 bit of CMD8).
    start_i   = 1'b1;
    cmd_i     = 40'h48000001AA;
    setting_i = 2'b01;
    @(posedge sd_clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(posedge sd_clk); #1;
    end
    check("bit20_drive", {118'd0, cmd_out_o, cmd_oe_o}, 120'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_lines", {118'd0, cmd_out_o, cmd_oe_o}, 120'd2);
    check("rst_async_flags", {117'd0, finish_o, crc_ok_o, index_ok_o}, 120'd0);
    check("rst_async_response", response_o, 120'd0);
    @(negedge sd_clk);
    rst = 1'b0;
    @(posedge sd_clk); #1;
    run_vec(11, vecs[1]);

    check("scoreboard_drained", 120'(sb.size()), 120'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_serial_host.md
# sd_cmd_serial_host

Bit-level engine for the SD CMD line, sitting directly downstream of `sd_cmd_master`. It takes a 40-bit command frame plus a response setting from the master and serialises it onto CMD with CRC7 and end bit. It then receives the card's 48- or 136-bit response, checks CRC7 and index, and returns `finish_o`, `crc_ok_o`, `index_ok_o` and a 120-bit response field to the master. Timeouts are not handled here; the master aborts a transfer via `go_idle_i`.

## Interface
- `NCC`, default 8: idle clocks after the end bit before `finish_o` when no response is expected.
- `sd_clk` input 1: SD clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: single-cycle request; ignored unless in IDLE.
- `setting_i` input 2: bit0 = response expected, bit1 = long (136-bit) response. Values: 00 none, 01 short, 11 long, 10 treated as 00.
- `cmd_i` input 40: {start 0, dir 1, index[5:0], arg[31:0]}; captured with `start_i`.
- `go_idle_i` input 1: synchronous abort.
- `cmd_dat_i` input 1: CMD line input from pad.
- `cmd_out_o` output 1: CMD line drive value.
- `cmd_oe_o` output 1: CMD output enable.
- `response_o` output 120: received content field, MSB-aligned.
- `crc_ok_o` output 1: response CRC7 matched.
- `index_ok_o` output 1: response index check passed.
- `finish_o` output 1: one-cycle pulse marking the end of a transfer.

## Operation
- States: IDLE, TX, WAIT, RX, NCC_WAIT, FIN.
- IDLE:
  - On `start_i`, latch `cmd_i` and `setting_i`, clear the CRC and bit counter, and go to TX.
  - While in IDLE, `cmd_oe_o`=0 and `cmd_out_o`=1.
- TX:
  - 48 cycles with `cmd_oe_o`=1.
  - Bits 0–39 are `cmd_i[39:0]`, MSB first. Bits 40–46 are CRC7 over those 40 bits, MSB first. Bit 47 is 1.
  - After TX, go to WAIT if a response is expected, otherwise to NCC_WAIT.
- WAIT:
  - `cmd_oe_o`=0.
  - The first cycle `cmd_dat_i`=0 is taken as the start bit. Go to RX with the counter at 1 and the CRC cleared.
  - There is no internal limit on how long WAIT lasts.
- RX:
  - Shift in the remaining 47 (short) or 135 (long) bits.
  - CRC7 coverage: short covers response bits 47..8; long covers bits 127..8.
  - Short response:
    - `response_o[119:88]` = bits 39..8 (argument); `response_o[87:0]`=0.
    - `index_ok_o` = (bits 45..40 == latched index).
  - Long response:
    - `response_o[119:0]` = bits 127..8.
    - `index_ok_o` = (bits 133..128 == 6'h3F).
  - `crc_ok_o` = (received CRC bits 7..1 == computed CRC) && (end bit == 1).
  - On the last bit, go to FIN.
- NCC_WAIT: count `NCC` cycles, then go to FIN.
- FIN:
  - `finish_o`=1 for one cycle, then go to IDLE.
  - `response_o`, `crc_ok_o` and `index_ok_o` are valid in the FIN cycle and hold until the next `start_i`.
  - For a no-response transfer, `crc_ok_o`=0 and `index_ok_o`=0.
- `go_idle_i` in any state:
  - Next state is IDLE; `cmd_oe_o`=0 the next cycle.
  - No `finish_o` pulse; flags are unchanged.
  - `go_idle_i` takes priority over a simultaneous `start_i`.

## Timing
- Reset values: `cmd_out_o`=1, `cmd_oe_o`=0, `finish_o`=0, `crc_ok_o`=0, `index_ok_o`=0, `response_o`=0, state IDLE.
- `start_i` sampled at edge N: the start bit drives from edge N+1 and the end bit from edge N+48. `cmd_oe_o` falls at edge N+49.
- No response: `finish_o` is high during cycle N+49+`NCC`.
- Response: `cmd_dat_i` is sampled on the rising edge. `finish_o` rises the edge after the last response bit is sampled.
- `cmd_dat_i`=0 during TX is ignored.
- WAIT is entered only after `cmd_oe_o` drops.
- `start_i` outside IDLE is ignored, with no side effects.

## Structure
- Shared package `sd_cmd_pkg`:
  - state enum;
  - `CMD_FRAME_W`=48, `RSP_SHORT_W`=48, `RSP_LONG_W`=136, `CRC_W`=7;
  - setting bit positions.
- Sub-module `sd_crc_7`: serial CRC7, polynomial x^7+x^3+1, with enable and clear inputs. One instance is shared between TX and RX.

## Test plan
- CMD0: `cmd_i`=40'h4000000000, `setting_i`=00. Serial stream = 48'h400000000095. `finish_o` is high exactly `NCC` cycles after the end bit. `crc_ok_o`=0.
- CMD8: `cmd_i`=40'h48000001AA, `setting_i`=01. Serial stream = 48'h48000001AA87. A card model replies after 5 idle cycles with index 8, arg 32'h000001AA and a correct CRC. Expect `response_o[119:88]`=32'h000001AA, `crc_ok_o`=1, `index_ok_o`=1.
- Same CMD8 with the reply's CRC LSB flipped: `crc_ok_o`=0, `index_ok_o`=1. Same CMD8 with reply index 9: `index_ok_o`=0.
- Long response, `setting_i`=11, reply content 120'h0102…0f with index 6'h3F and correct CRC: `response_o`=120'h0102030405060708090a0b0c0d0e0f, both flags 1. Latency is 136 bits from the start bit.
- No card reply for 200 cycles, then `go_idle_i` pulse: `cmd_oe_o`=0 and no `finish_o`. A following CMD0 transfer completes normally.
- Reset asserted mid-TX (bit 20): all outputs take their reset values immediately, asynchronously.
- `start_i` pulsed during RX: ignored, and the in-flight response completes unchanged.
